// File: rtl/seq_detector_param_if.sv
// Bus bundle for seq_detector_param: serial bit stream, pattern load port and
// detector outputs (plus a state debug tap).
interface seq_detector_param_if #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8
);
   localparam int LW = $clog2(PAT_W + 1);

   // No back-pressure: x is consumed on every rising edge where x_valid is high.
   logic             x;
   logic             x_valid;
   logic             pat_load;
   logic [PAT_W-1:0] pat_in;
   logic [LW-1:0]    pat_len;
   logic             overlap;
   logic             clr_cnt;
   logic             y;
   logic [CNT_W-1:0] match_cnt;
   logic             cfg_err;
   logic             armed;
   logic             dbg_state;

   modport master (
      output x, x_valid, pat_load, pat_in, pat_len, overlap, clr_cnt,
      input  y, match_cnt, cfg_err, armed, dbg_state
   );

   modport slave (
      input  x, x_valid, pat_load, pat_in, pat_len, overlap, clr_cnt,
      output y, match_cnt, cfg_err, armed, dbg_state
   );
endinterface

// File: rtl/seq_detector_param.sv
// Programmable serial pattern detector with overlap mode and a saturating match
// counter that is only built when SEQDET_MATCH_CNT_EN is defined.
module seq_detector_param #(
   parameter int PAT_W = 8,
   parameter int CNT_W = 8
) (
   input logic                 clk,
   input logic                 reset,
   seq_detector_param_if.slave bus
);
   localparam int LW = $clog2(PAT_W + 1);
   localparam logic [LW-1:0] MAX_LEN = LW'(PAT_W);

   typedef enum logic {UNCFG = 1'b0, RUN = 1'b1} state_e;

   state_e           state_q;
   logic [PAT_W-1:0] hist_q, hist_d;
   logic [PAT_W-1:0] pat_q;
   logic [LW-1:0]    len_q;
   logic [LW-1:0]    fill_q, fill_d;
   logic             ovl_q;
   logic             y_q;
   logic             cfg_err_q;
   logic [PAT_W-1:0] mask;
   logic [LW-1:0]    fill_inc;
   logic             load_ok;
   logic             match_d;

   assign load_ok = (bus.pat_len != '0) && (bus.pat_len <= MAX_LEN);

   always_comb begin
      mask = '0;
      for (int i = 0; i < PAT_W; i++) mask[i] = (i < int'(len_q));
      hist_d   = {hist_q[PAT_W-2:0], bus.x};
      fill_inc = (fill_q == len_q) ? fill_q : fill_q + LW'(1);
      match_d  = !bus.pat_load && (state_q == RUN) && bus.x_valid &&
                 (fill_inc == len_q) && (((hist_d ^ pat_q) & mask) == '0);
      // Non-overlapping mode needs a full fresh window before the next match.
      fill_d   = (match_d && !ovl_q) ? '0 : fill_inc;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= UNCFG;
         hist_q    <= '0;
         pat_q     <= '0;
         len_q     <= '0;
         fill_q    <= '0;
         ovl_q     <= 1'b0;
         y_q       <= 1'b0;
         cfg_err_q <= 1'b0;
      end else begin
         y_q <= 1'b0;
         if (bus.pat_load) begin
            hist_q <= '0;
            fill_q <= '0;
            if (load_ok) begin
               state_q   <= RUN;
               pat_q     <= bus.pat_in;
               len_q     <= bus.pat_len;
               ovl_q     <= bus.overlap;
               cfg_err_q <= 1'b0;
            end else begin
               state_q   <= UNCFG;
               cfg_err_q <= 1'b1;
            end
         end else if (state_q == RUN && bus.x_valid) begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            y_q    <= match_d;
         end
      end
   end

`ifdef SEQDET_MATCH_CNT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (bus.clr_cnt)                   cnt_d = '0;
      else if (match_d && cnt_q != '1)   cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign bus.match_cnt = cnt_q;
`else
   logic unused_clr_cnt;
   assign unused_clr_cnt = bus.clr_cnt;
   assign bus.match_cnt  = '0;
`endif

   assign bus.y         = y_q;
   assign bus.cfg_err   = cfg_err_q;
   assign bus.armed     = (state_q == RUN);
   assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param: dut_a (CNT_W=8) covers the main flows,
// dut_b (CNT_W=2) covers counter saturation and clear priority.
module tb_seq_detector_param;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  seq_detector_param_if #(.PAT_W(8), .CNT_W(8)) bus_a ();
  seq_detector_param_if #(.PAT_W(8), .CNT_W(2)) bus_b ();

  seq_detector_param #(.PAT_W(8), .CNT_W(8)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  seq_detector_param #(.PAT_W(8), .CNT_W(2)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // scoreboard
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ec(input int n);
`ifdef SEQDET_MATCH_CNT_EN
    return n;
`else
    return (n == 0) ? 0 : 0;
`endif
  endfunction

  // drivers
  task automatic load(input bit sel, input logic [7:0] pat, input logic [3:0] len,
                      input logic ovl, input logic exp_armed, input logic exp_err);
    if (!sel) begin
      bus_a.pat_in = pat; bus_a.pat_len = len; bus_a.overlap = ovl; bus_a.pat_load = 1'b1;
    end else begin
      bus_b.pat_in = pat; bus_b.pat_len = len; bus_b.overlap = ovl; bus_b.pat_load = 1'b1;
    end
    tick();
    bus_a.pat_load = 1'b0; bus_b.pat_load = 1'b0; bus_a.x_valid = 1'b0;
    if (!sel) begin
      chk("load_armed", bus_a.armed, exp_armed);
      chk("load_err", bus_a.cfg_err, exp_err);
    end else begin
      chk("load_armed_b", bus_b.armed, exp_armed);
      chk("load_err_b", bus_b.cfg_err, exp_err);
    end
  endtask

  task automatic send(input bit sel, input logic b, input logic exp_y, input string tag);
    if (!sel) begin bus_a.x = b; bus_a.x_valid = 1'b1; end
    else      begin bus_b.x = b; bus_b.x_valid = 1'b1; end
    tick();
    bus_a.x_valid = 1'b0; bus_b.x_valid = 1'b0;
    if (!sel) chk(tag, bus_a.y, exp_y);
    else      chk(tag, bus_b.y, exp_y);
  endtask

  task automatic idle(input string tag);
    tick();
    chk(tag, bus_a.y, 1'b0);
  endtask

  task automatic clear_a();
    bus_a.clr_cnt = 1'b1;
    tick();
    bus_a.clr_cnt = 1'b0;
    chk("clr_cnt", bus_a.match_cnt, 0);
  endtask

  logic [6:0] s7;
  logic [6:0] y7;

  initial begin
    bus_a.x = 0; bus_a.x_valid = 0; bus_a.pat_load = 0; bus_a.pat_in = 0;
    bus_a.pat_len = 0; bus_a.overlap = 0; bus_a.clr_cnt = 0;
    bus_b.x = 0; bus_b.x_valid = 0; bus_b.pat_load = 0; bus_b.pat_in = 0;
    bus_b.pat_len = 0; bus_b.overlap = 0; bus_b.clr_cnt = 0;
    #1 reset = 1'b0;
    #1;
    chk("rst_y", bus_a.y, 0);
    chk("rst_cnt", bus_a.match_cnt, 0);
    chk("rst_err", bus_a.cfg_err, 0);
    chk("rst_armed", bus_a.armed, 0);
    tick(); tick();
    reset = 1'b1;
    send(0, 1'b1, 1'b0, "uncfg_ignore");

    // overlapping 1011 over 1,0,1,1,0,1,1
    load(0, 8'b1011, 4'd4, 1'b1, 1'b1, 1'b0);
    clear_a();
    s7 = 7'b1011011; y7 = 7'b0001001;
    for (int i = 6; i >= 0; i--) send(0, s7[i], y7[i], "ovl_y");
    chk("ovl_cnt", bus_a.match_cnt, ec(2));
    idle("ovl_idle_y");

    // non-overlapping, same stream; reload must not touch the counter
    load(0, 8'b1011, 4'd4, 1'b0, 1'b1, 1'b0);
    chk("load_keeps_cnt", bus_a.match_cnt, ec(2));
    clear_a();
    y7 = 7'b0001000;
    for (int i = 6; i >= 0; i--) send(0, s7[i], y7[i], "novl_y");
    chk("novl_cnt", bus_a.match_cnt, ec(1));

    // invalid length
    load(0, 8'b1011, 4'd9, 1'b1, 1'b0, 1'b1);
    for (int i = 6; i >= 3; i--) send(0, s7[i], 1'b0, "bad_len_y");
    chk("bad_len_cnt", bus_a.match_cnt, ec(1));
    load(0, 8'b1011, 4'd0, 1'b1, 1'b0, 1'b1);

    // bit presented with pat_load is dropped
    bus_a.x = 1'b1; bus_a.x_valid = 1'b1;
    load(0, 8'b1011, 4'd4, 1'b0, 1'b1, 1'b0);
    send(0, 1'b0, 1'b0, "drop_b0");
    send(0, 1'b1, 1'b0, "drop_b1");
    send(0, 1'b1, 1'b0, "drop_b2");

    // gaps between valid bits
    load(0, 8'b1011, 4'd4, 1'b0, 1'b1, 1'b0);
    clear_a();
    send(0, 1'b1, 1'b0, "gap_b0"); idle("gap_i0");
    send(0, 1'b0, 1'b0, "gap_b1"); idle("gap_i1");
    send(0, 1'b1, 1'b0, "gap_b2"); idle("gap_i2");
    send(0, 1'b1, 1'b1, "gap_b3"); idle("gap_i3");
    chk("gap_cnt", bus_a.match_cnt, ec(1));

    // CNT_W=2 saturation, then clear wins over a match
    load(1, 8'b11, 4'd2, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      send(1, 1'b1, (i == 0) ? 1'b0 : 1'b1, "sat_y");
      chk("sat_cnt", bus_b.match_cnt, ec((i > 3) ? 3 : i));
    end
    bus_b.clr_cnt = 1'b1;
    send(1, 1'b1, 1'b1, "clr_match_y");
    bus_b.clr_cnt = 1'b0;
    chk("clr_match_cnt", bus_b.match_cnt, 0);

    // asynchronous reset mid-stream
    load(0, 8'b1011, 4'd4, 1'b1, 1'b1, 1'b0);
    send(0, 1'b1, 1'b0, "pre_rst_b0");
    send(0, 1'b0, 1'b0, "pre_rst_b1");
    send(0, 1'b1, 1'b0, "pre_rst_b2");
    #2 reset = 1'b0;
    #1;
    chk("arst_y", bus_a.y, 0);
    chk("arst_cnt", bus_a.match_cnt, 0);
    chk("arst_err", bus_a.cfg_err, 0);
    chk("arst_armed", bus_a.armed, 0);
    #2 reset = 1'b1;
    send(0, 1'b1, 1'b0, "post_rst_uncfg");
    chk("post_rst_armed", bus_a.armed, 0);
    load(0, 8'b1011, 4'd4, 1'b1, 1'b1, 1'b0);
    send(0, 1'b1, 1'b0, "reload_b0");
    send(0, 1'b0, 1'b0, "reload_b1");
    send(0, 1'b1, 1'b0, "reload_b2");
    send(0, 1'b1, 1'b1, "reload_b3");
    chk("reload_cnt", bus_a.match_cnt, ec(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
